wb_i2c_byte_master: RTL and testbench
=====================================

Name: wb_i2c_byte_master

Overview:
- Wishbone classic slave that turns register writes into I2C bus byte transactions: START, address/data byte write, data byte read, ACK/NACK and STOP.
- Sits directly downstream of the video-encoder configuration sequencer (a Wishbone master). It is the only block driving the encoder's SCL/SDA pads.
- One command per register write. The master polls the status register until the transfer completes.

Parameters:
PRE_RST, 16'hFFFF, reset value of the prescale register.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
adr  in  3  Wishbone register address
din  in  8  Wishbone write data (master to this block)
dout  out  8  Wishbone read data
cyc  in  1  Wishbone cycle
stb  in  1  Wishbone strobe
we  in  1  Wishbone write enable
sel  in  1  Wishbone byte select (ignored)
ack  out  1  Wishbone acknowledge
err  out  1  Wishbone error (tied 0)
rty  out  1  Wishbone retry (tied 0)
scl_i  in  1  SCL pad input
scl_oen  out  1  SCL output enable, active-low (pad output is constant 0)
sda_i  in  1  SDA pad input
sda_oen  out  1  SDA output enable, active-low (pad output is constant 0)

Behaviour:
- Reset values: ack=0, dout=0, scl_oen=1, sda_oen=1, PRER=PRE_RST, CTR=0, TXR=0, RXR=0, CR=0, SR=0, FSM=IDLE.
- Wishbone timing:
  - ack=1 for exactly one cycle, in the cycle after cyc&stb is sampled with ack=0. Back-to-back accesses therefore take 2 cycles each.
  - Register write happens on cyc&stb&we&~ack.
  - dout is registered and valid while ack=1.
- Register map:
  - 0: PRERlo (R/W)
  - 1: PRERhi (R/W)
  - 2: CTR (R/W). bit7 = EN.
  - 3: TXR on write, RXR on read.
  - 4: CR on write, SR on read.
  - 5-7: read 0, writes ignored.
- PRER writes are ignored while EN=1.
- CR bits: 7 STA, 6 STO, 5 RD, 4 WR, 3 ACK (0 = drive ACK after a read, 1 = drive NACK).
  - CR is accepted only when EN=1 and TIP=0; otherwise the write is ignored.
  - Command bits self-clear when the command completes.
- SR bits: 7 RxACK (SDA sampled in the ACK slot of a write), 6 BUSY, 1 TIP. All other bits read 0.
- BUSY:
  - Set when START is issued, cleared when STOP completes.
  - BUSY stays 1 between commands that have no STO.
- Bit timing:
  - A tick occurs every PRER+1 clk cycles.
  - Each bit and each START/STOP condition is 4 ticks (phases A-D).
  - SCL frequency = clk / (4*(PRER+1)).
- Clock stretching: in any phase where SCL is released, the tick counter holds until scl_i=1.
- Per-bit waveforms:
  - START: A SDA=1,SCL=1; B SDA=1,SCL=1; C SDA=0,SCL=1; D SDA=0,SCL=0.
  - STOP: A SDA=0,SCL=0; B SDA=0,SCL=1; C SDA=1,SCL=1; D SDA=1,SCL=1.
  - Data bit: A SCL=0 with SDA set up; B and C SCL=1, sda_i sampled at the end of B; D SCL=0.
  - SDA changes only while SCL=0.
- Byte FSM: IDLE -> [STA] START -> (WR: WRITE | RD: READ) -> ACK -> [STO] STOP -> IDLE.
  - WRITE sends TXR MSB first over 8 bits. The ACK slot releases SDA and latches RxACK.
  - READ releases SDA for 8 bits, shifts into RXR MSB first, then drives the ACK bit value in the ACK slot.
  - WR and RD both set: WR wins and RD is ignored.
  - STA only or STO only: just the condition is generated.
- TIP:
  - Set in the cycle after an accepted CR write.
  - Cleared in the same cycle the FSM returns to IDLE.
  - RXR updates when TIP falls; reading RXR while TIP=1 returns the previous byte.
- EN cleared mid-transfer:
  - FSM forced to IDLE on the next cycle.
  - scl_oen=sda_oen=1, TIP=0, BUSY=0, CR cleared.
- rst asserted mid-transfer: pads are released immediately (asynchronous path).

Test Plan:
1. Reset, read addresses 0-4 -> 8'hFF, 8'hFF, 0, 0, 0. ack is a 1-cycle pulse 1 cycle after stb.
2. PRER=4, EN=1, TXR=8'h54, CR=8'h90 -> START then 8 bits 0,1,0,1,0,1,0,0; SCL period 20 clk; sda_i=0 in the ACK slot gives SR=8'h40 after TIP falls.
3. Continuing from 2: TXR=8'h3C, CR=8'h50 -> byte written then STOP; SR returns to 8'h00; pads released.
4. Read with CR=8'h28, slave drives 8'hA5 -> RXR=8'hA5; SDA released (NACK) in the 9th bit; RXR read during TIP returns the old value.
5. Hold scl_i=0 for 50 clk during phase B -> bit stretched by 50 clk; sample taken after release.
6. CR write during TIP, PRER write while EN=1, EN=0 mid-byte -> first two ignored; third gives pads released, SR=0 within 2 clk.

Source files
------------

// File: rtl/wb_i2c_byte_master_if.sv
// Wishbone classic register port of the I2C byte master.
interface wb_i2c_byte_master_if;
  logic [2:0] adr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       cyc;
  logic       stb;
  logic       we;
  logic       sel;
  logic       ack;
  logic       err;
  logic       rty;

  modport slave  (input  adr, din, cyc, stb, we, sel, output dout, ack, err, rty);
  modport master (output adr, din, cyc, stb, we, sel, input  dout, ack, err, rty);
endinterface

// File: rtl/wb_i2c_byte_master.sv
// Wishbone-programmed I2C byte master: START, byte write/read, ACK/NACK, STOP,
// one command per CR write, with prescaled 4-phase bit timing and SCL stretching.
module wb_i2c_byte_master #(
  parameter logic [15:0] PRE_RST = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  wb_i2c_byte_master_if.slave        wb,
  input  logic                       scl_i,
  output logic                       scl_oen,
  input  logic                       sda_i,
  output logic                       sda_oen
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_ACK, S_STOP} state_e;

  localparam int STA = 4, STO = 3, RD = 2, WR = 1, ACKB = 0;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d, prer_q;
  logic [7:0]  ctr_q, txr_q, rxr_q, rxr_d, shift_q, shift_d, dout_q, rdata;
  logic [4:0]  cr_q, cr_d;
  logic        rxack_q, rxack_d, busy_q, busy_d, tip_q, tip_d, ack_q;
  logic        scl_q, scl_d, sda_q, sda_d;
  logic        en, acc, wr_acc, cr_acc, stretch, done;
  logic        unused_sel;

  assign en         = ctr_q[7];
  assign acc        = wb.cyc & wb.stb & ~ack_q;
  assign wr_acc     = acc & wb.we;
  assign cr_acc     = wr_acc && (wb.adr == 3'd4) && en && !tip_q;
  assign stretch    = scl_q & ~scl_i;
  assign unused_sel = wb.sel;

  assign wb.ack  = ack_q;
  assign wb.dout = dout_q;
  assign wb.err  = 1'b0;
  assign wb.rty  = 1'b0;
  assign scl_oen = scl_q;
  assign sda_oen = sda_q;

  always_comb begin
    rdata = 8'h00;
    case (wb.adr)
      3'd0:    rdata = prer_q[7:0];
      3'd1:    rdata = prer_q[15:8];
      3'd2:    rdata = ctr_q;
      3'd3:    rdata = rxr_q;
      3'd4:    rdata = {rxack_q, busy_q, 4'b0000, tip_q, 1'b0};
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prer_q <= PRE_RST;
      ctr_q  <= 8'h00;
      txr_q  <= 8'h00;
      ack_q  <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      ack_q <= acc;
      if (acc && !wb.we) dout_q <= rdata;
      if (wr_acc) begin
        case (wb.adr)
          3'd0:    if (!en) prer_q[7:0]  <= wb.din;
          3'd1:    if (!en) prer_q[15:8] <= wb.din;
          3'd2:    ctr_q <= wb.din;
          3'd3:    txr_q <= wb.din;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    rxr_d   = rxr_q;
    shift_d = shift_q;
    cr_d    = cr_q;
    rxack_d = rxack_q;
    busy_d  = busy_q;
    tip_d   = tip_q;
    done    = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      tip_d   = 1'b0;
      busy_d  = 1'b0;
      cr_d    = 5'b0;
    end else begin
      if (cr_acc) begin
        cr_d  = wb.din[7:3];
        tip_d = 1'b1;
      end
      case (state_q)
        S_IDLE: if (tip_q) begin
          cnt_d   = prer_q;
          phase_d = 2'd0;
          bit_d   = 3'd0;
          if (cr_q[STA]) begin
            state_d = S_START;
            busy_d  = 1'b1;
          end
          else if (cr_q[WR])  state_d = S_WRITE;
          else if (cr_q[RD])  state_d = S_READ;
          else if (cr_q[STO]) state_d = S_STOP;
          else                done    = 1'b1;
        end
        default: if (!stretch) begin
          if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
          else begin
            cnt_d   = prer_q;
            phase_d = phase_q + 2'd1;
            // end of phase B is the SDA sample point
            if (phase_q == 2'd1) begin
              if (state_q == S_READ) shift_d = {shift_q[6:0], sda_i};
              if (state_q == S_ACK && cr_q[WR]) rxack_d = sda_i;
            end
            if (phase_q == 2'd3) begin
              case (state_q)
                S_START:
                  if (cr_q[WR])       state_d = S_WRITE;
                  else if (cr_q[RD])  state_d = S_READ;
                  else if (cr_q[STO]) state_d = S_STOP;
                  else                done    = 1'b1;
                S_WRITE, S_READ:
                  if (bit_q == 3'd7) state_d = S_ACK;
                  else               bit_d   = bit_q + 3'd1;
                S_ACK:
                  if (cr_q[STO]) state_d = S_STOP;
                  else           done    = 1'b1;
                S_STOP: begin
                  busy_d = 1'b0;
                  done   = 1'b1;
                end
                default: done = 1'b1;
              endcase
            end
          end
        end
      endcase
      if (done) begin
        state_d = S_IDLE;
        tip_d   = 1'b0;
        cr_d    = 5'b0;
        rxr_d   = shift_q;
      end
    end

    // pads follow the next state so they are registered and reset asynchronously
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      S_IDLE:  if (busy_d) begin
        scl_d = 1'b0;
        sda_d = sda_q;
      end
      S_START: begin
        scl_d = (phase_d != 2'd3);
        sda_d = (phase_d < 2'd2);
      end
      S_STOP: begin
        scl_d = (phase_d != 2'd0);
        sda_d = (phase_d >= 2'd2);
      end
      S_WRITE: begin
        scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_d = txr_q[~bit_d];
      end
      S_READ:  scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
      S_ACK: begin
        scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_d = cr_q[WR] ? 1'b1 : cr_q[ACKB];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      bit_q   <= 3'd0;
      cnt_q   <= 16'd0;
      rxr_q   <= 8'h00;
      shift_q <= 8'h00;
      cr_q    <= 5'b0;
      rxack_q <= 1'b0;
      busy_q  <= 1'b0;
      tip_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      rxr_q   <= rxr_d;
      shift_q <= shift_d;
      cr_q    <= cr_d;
      rxack_q <= rxack_d;
      busy_q  <= busy_d;
      tip_q   <= tip_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end
endmodule

// File: tb/tb_wb_i2c_byte_master.sv
// Directed bench for wb_i2c_byte_master with a small I2C slave/bus monitor.
`timescale 1ns/1ps
module tb_wb_i2c_byte_master;
  logic clk, rst;
  logic scl_i, scl_oen, sda_i, sda_oen;
  logic scl_hold, sda_f0, sda_slv;
  logic [7:0] rd_byte;
  int mode;
  int n_chk, n_pass;

  wb_i2c_byte_master_if wbi ();

  wb_i2c_byte_master #(.PRE_RST(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .wb(wbi.slave),
    .scl_i(scl_i), .scl_oen(scl_oen), .sda_i(sda_i), .sda_oen(sda_oen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign scl_i = scl_oen & ~scl_hold;
  assign sda_i = sda_oen & sda_slv & ~sda_f0;

  // bus monitor: SCL rise captures, START/STOP counts, slave bit position
  logic bits_q[$];
  longint rise_t[$];
  int nstart, nstop, bitpos, hi_cnt, idx;
  logic scl_p, sda_p;

  initial begin
    scl_p = 1'b1; sda_p = 1'b1; nstart = 0; nstop = 0; bitpos = 0; hi_cnt = 0;
  end

  always @(negedge clk) begin
    if (scl_i && !scl_p) begin
      bits_q.push_back(sda_i);
      rise_t.push_back($time);
    end
    if (!scl_i && scl_p) bitpos <= bitpos + 1;
    hi_cnt <= scl_i ? hi_cnt + 1 : 0;
    if (scl_i && hi_cnt >= 16) bitpos <= 0;
    if (scl_i && scl_p && sda_p && !sda_i) begin nstart <= nstart + 1; bitpos <= 0; end
    if (scl_i && scl_p && !sda_p && sda_i) begin nstop <= nstop + 1; bitpos <= 0; end
    scl_p <= scl_i;
    sda_p <= sda_i;
  end

  always_comb begin
    sda_slv = 1'b1;
    idx = 0;
    if (bitpos != 0) begin
      idx = (bitpos - 1) % 9;
      if (mode == 1 && idx == 8) sda_slv = 1'b0;
      else if (mode == 2 && idx < 8) sda_slv = rd_byte[7-idx];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [7:0] d,
                         output logic [7:0] q, output int lat);
    @(posedge clk); #1;
    wbi.cyc = 1'b1; wbi.stb = 1'b1; wbi.we = w; wbi.adr = a; wbi.din = d;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!wbi.ack && lat < 8);
    q = wbi.dout;
    if (!wbi.ack) chk("wb_ack_seen", wbi.ack, 1);
    wbi.cyc = 1'b0; wbi.stb = 1'b0; wbi.we = 1'b0;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q; int lat;
    wb_xfer(1'b1, a, d, q, lat);
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [7:0] q);
    int lat;
    wb_xfer(1'b0, a, 8'h00, q, lat);
  endtask

  task automatic wait_idle(output logic [7:0] sr);
    int n;
    n = 0; sr = 8'h02;
    while (sr[1] && n < 600) begin wb_rd(3'd4, sr); n++; end
    chk("tip_clear", sr[1], 0);
  endtask

  task automatic wait_oen(input logic v);
    int n;
    n = 0;
    while (scl_oen !== v && n < 400) begin @(negedge clk); n++; end
    if (scl_oen !== v) chk("scl_oen_wait", scl_oen, v);
  endtask

  task automatic get_byte(input int base, output logic [7:0] b, output logic a);
    b = 'x; a = 'x;
    if (bits_q.size() >= base + 9) begin
      for (int i = 0; i < 8; i++) b = {b[6:0], bits_q[base+i]};
      a = bits_q[base+8];
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [7:0] q, sr, b;
  logic a;
  int base, lat, s0;
  longint t1, t2;
  logic [7:0] rst_exp [5];

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; scl_hold = 1'b0; sda_f0 = 1'b0; mode = 0; rd_byte = 8'h00;
    wbi.cyc = 0; wbi.stb = 0; wbi.we = 0; wbi.adr = 0; wbi.din = 0; wbi.sel = 1'b1;
    rst_exp = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    repeat (3) @(posedge clk); #1;
    chk("rst_scl_oen", scl_oen, 1);
    chk("rst_sda_oen", sda_oen, 1);
    chk("rst_ack", wbi.ack, 0);
    chk("rst_dout", wbi.dout, 0);
    @(negedge clk); rst = 1'b0;

    // 1: reset register values and ack pulse timing
    for (int i = 0; i < 5; i++) begin
      wb_xfer(1'b0, 3'(i), 8'h00, q, lat);
      chk($sformatf("rst_reg%0d", i), q, rst_exp[i]);
    end
    wb_xfer(1'b0, 3'd2, 8'h00, q, lat);
    chk("ack_latency", lat, 1);
    @(posedge clk); #1;
    chk("ack_one_cycle", wbi.ack, 0);

    // 2: START + write 0x54, slave ACKs
    wb_wr(3'd0, 8'h04); wb_wr(3'd1, 8'h00); wb_wr(3'd2, 8'h80);
    wb_wr(3'd3, 8'h54);
    mode = 1; base = bits_q.size(); s0 = nstart;
    wb_wr(3'd4, 8'h90);
    wait_idle(sr);
    chk("wr1_sr", sr, 8'h40);
    get_byte(base, b, a);
    chk("wr1_byte", b, 8'h54);
    chk("wr1_ack_bit", a, 0);
    chk("wr1_start", nstart - s0, 1);
    if (rise_t.size() >= base + 2) chk("scl_period", 32'((rise_t[base+1] - rise_t[base]) / 10), 20);
    else chk("scl_period_edges", rise_t.size(), base + 2);

    // 3: write 0x3C then STOP
    wb_wr(3'd3, 8'h3C);
    base = bits_q.size(); s0 = nstop;
    wb_wr(3'd4, 8'h50);
    wait_idle(sr);
    chk("wr2_sr", sr, 8'h00);
    get_byte(base, b, a);
    chk("wr2_byte", b, 8'h3C);
    chk("wr2_stop", nstop - s0, 1);
    chk("wr2_pads", {scl_oen, sda_oen}, 2'b11);

    // 4: read 0xA5 with NACK, RXR stale during TIP
    repeat (20) @(posedge clk);
    mode = 2; rd_byte = 8'hA5; base = bits_q.size();
    wb_wr(3'd4, 8'h28);
    wb_rd(3'd3, q);
    chk("rd_rxr_during_tip", q, 8'h00);
    wait_idle(sr);
    chk("rd_sr", sr, 8'h00);
    wb_rd(3'd3, q);
    chk("rd_rxr", q, 8'hA5);
    get_byte(base, b, a);
    chk("rd_bus_byte", b, 8'hA5);
    chk("rd_nack_bit", a, 1);

    // 5: clock stretching on bit 0 phase B
    repeat (20) @(posedge clk);
    mode = 2; rd_byte = 8'h80;
    wb_wr(3'd4, 8'h20);
    wait_oen(1'b0);
    scl_hold = 1'b1; sda_f0 = 1'b1;
    wait_oen(1'b1);
    t1 = $time;
    repeat (50) @(negedge clk);
    scl_hold = 1'b0; sda_f0 = 1'b0;
    wait_oen(1'b0);
    wait_oen(1'b1);
    t2 = $time;
    chk("stretch_bit_time", 32'((t2 - t1) / 10), 70);
    wait_idle(sr);
    wb_rd(3'd3, q);
    chk("stretch_rxr", q, 8'h80);

    // 6: CR during TIP ignored, PRER locked while EN, EN drop mid-byte
    repeat (20) @(posedge clk);
    mode = 1; wb_wr(3'd3, 8'hAA);
    base = bits_q.size();
    wb_wr(3'd4, 8'h10);
    wb_wr(3'd4, 8'h20);
    wait_idle(sr);
    get_byte(base, b, a);
    chk("cr_ignored_byte", b, 8'hAA);
    wb_wr(3'd0, 8'h09);
    wb_rd(3'd0, q);
    chk("prer_locked", q, 8'h04);
    repeat (20) @(posedge clk);
    wb_wr(3'd4, 8'h10);
    repeat (60) @(posedge clk);
    wb_wr(3'd2, 8'h00);
    @(posedge clk); #1;
    chk("en_off_pads", {scl_oen, sda_oen}, 2'b11);
    wb_rd(3'd4, q);
    chk("en_off_sr", q, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
